// File: rtl/commit_trace_uart.sv
// Commit-trace formatter: queues retired-instruction records and streams each
// one as a lowercase-hex ASCII line to a UART TX port, one byte per cycle.
module commit_trace_uart #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       push,
    input  logic [CNT_W-1:0]           count_in,
    input  logic [DATA_W+7+ADDR_W-1:0] info_in,
    input  logic                       tx_ready,
    output logic                       uart_en,
    output logic [7:0]                 uart_data,
    output logic                       stall,
    output logic                       dropped,
    output logic                       busy
);

    localparam int unsigned INFO_W    = DATA_W + 7 + ADDR_W;
    localparam int unsigned REC_W     = CNT_W + INFO_W;
    localparam int unsigned AW        = $clog2(DEPTH);
    localparam int unsigned NC        = CNT_W / 4;
    localparam int unsigned NA        = ADDR_W / 4;
    localparam int unsigned ND        = DATA_W / 4;
    localparam int unsigned P_TYPE    = NC + NA + 4;
    localparam int unsigned LEN_SHORT = NC + NA + 6;
    localparam int unsigned LEN_BR    = NC + NA + 8;
    localparam int unsigned LEN_REG   = NC + NA + ND + 10;
    localparam int unsigned K_W       = $clog2(LEN_REG);

    typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

    state_t             state;
    logic [REC_W-1:0]   mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        count, count_next;
    logic [REC_W-1:0]   head;
    logic [CNT_W-1:0]   line_cnt;
    logic [ADDR_W-1:0]  line_addr;
    logic [DATA_W-1:0]  line_data;
    logic [4:0]         line_rd;
    logic [1:0]         line_type;
    logic [K_W-1:0]     k, last_k;
    logic               active, full, pop, push_ok, push_drop, emit;
    logic [7:0]         byte_c;
    int unsigned        kk, r;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h57 + 8'(n));
    endfunction

    // Pop-before-push lets a full FIFO accept a push in the cycle it pops.
    always_comb begin
        active     = rdy && !rst;
        full       = (count == (AW+1)'(DEPTH));
        pop        = active && (state == LOAD);
        push_ok    = active && push && (!full || pop);
        push_drop  = active && push && full && !pop;
        emit       = active && (state == EMIT) && tx_ready;
        count_next = count + (AW+1)'(push_ok) - (AW+1)'(pop);
        head       = mem[rd_ptr];
    end

    always_comb begin
        case (line_type)
            2'b00:   last_k = K_W'(LEN_REG - 1);
            2'b10:   last_k = K_W'(LEN_BR - 1);
            default: last_k = K_W'(LEN_SHORT - 1);
        endcase
    end

    // Byte k of the current line, derived directly from the line register.
    always_comb begin
        byte_c = 8'h0a;
        kk     = 32'(k);
        r      = 0;
        if (kk == 0)                 byte_c = 8'h5b;
        else if (kk <= NC)           byte_c = hex_ascii(4'(line_cnt >> (4 * (NC - kk))));
        else if (kk == NC + 1)       byte_c = 8'h5d;
        else if (kk == NC + 2)       byte_c = 8'h20;
        else if (kk <= NC + NA + 2)  byte_c = hex_ascii(4'(line_addr >> (4 * (NC + NA + 2 - kk))));
        else if (kk == NC + NA + 3)  byte_c = 8'h20;
        else if (kk == P_TYPE) begin
            case (line_type)
                2'b00:   byte_c = 8'h72;
                2'b01:   byte_c = 8'h73;
                2'b10:   byte_c = 8'h62;
                default: byte_c = 8'h3f;
            endcase
        end else begin
            r = kk - (P_TYPE + 1);
            case (line_type)
                2'b00: begin
                    if (r == 0 || r == 3)  byte_c = 8'h20;
                    else if (r == 1)       byte_c = 8'h30 + 8'(line_rd[4]);
                    else if (r == 2)       byte_c = hex_ascii(line_rd[3:0]);
                    else if (r <= ND + 3)  byte_c = hex_ascii(4'(line_data >> (4 * (ND + 3 - r))));
                    else                   byte_c = 8'h0a;
                end
                2'b10: begin
                    if (r == 0)            byte_c = 8'h20;
                    else if (r == 1)       byte_c = 8'h30 + 8'(line_data[0]);
                    else                   byte_c = 8'h0a;
                end
                default:                   byte_c = 8'h0a;
            endcase
        end
    end

    assign uart_en   = emit;
    assign uart_data = emit ? byte_c : 8'h00;
    assign stall     = full;
    assign busy      = (count != '0) || (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            k         <= '0;
            dropped   <= 1'b0;
            line_cnt  <= '0;
            line_addr <= '0;
            line_data <= '0;
            line_rd   <= '0;
            line_type <= '0;
        end else if (rdy) begin
            if (push_ok) begin
                mem[wr_ptr] <= {count_in, info_in};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            if (push_drop) dropped <= 1'b1;
            case (state)
                IDLE: if (count_next != '0) state <= LOAD;
                LOAD: begin
                    line_addr <= head[ADDR_W-1:0];
                    line_type <= head[ADDR_W+1:ADDR_W];
                    line_rd   <= head[ADDR_W+6:ADDR_W+2];
                    line_data <= head[INFO_W-1:ADDR_W+7];
                    line_cnt  <= head[REC_W-1:INFO_W];
                    k         <= '0;
                    state     <= EMIT;
                end
                EMIT: if (tx_ready) begin
                    if (k == last_k) begin
                        k     <= '0;
                        state <= (count_next != '0) ? LOAD : IDLE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_commit_trace_uart.sv
// Bench for commit_trace_uart: directed scenarios plus a randomized phase,
// all emitted bytes scored against lines rendered with $sformatf.
module tb_commit_trace_uart;

    logic        clk = 1'b0;
    logic        rst, rdy, push, tx_ready;
    logic [31:0] count_in;
    logic [70:0] info_in;
    logic        uart_en;
    logic [7:0]  uart_data;
    logic        stall, dropped, busy;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          n_bytes = 0;
    logic [7:0]  exp_q[$];
    int          en_cyc[$];
    logic [7:0]  mon_exp;

    commit_trace_uart dut (
        .clk(clk), .rst(rst), .rdy(rdy), .push(push),
        .count_in(count_in), .info_in(info_in), .tx_ready(tx_ready),
        .uart_en(uart_en), .uart_data(uart_data), .stall(stall),
        .dropped(dropped), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic string line_str(input logic [31:0] c, input logic [31:0] a,
                                       input logic [4:0] r, input logic [1:0] t,
                                       input logic [31:0] d);
        case (t)
            2'd0:    return $sformatf("[%h] %h r %h %h\n", c, a, r, d);
            2'd1:    return $sformatf("[%h] %h s\n", c, a);
            2'd2:    return $sformatf("[%h] %h b %0d\n", c, a, d[0]);
            default: return $sformatf("[%h] %h ?\n", c, a);
        endcase
    endfunction

    // Scoreboard: every emitted byte must be the next expected one.
    always @(negedge clk) begin
        if (uart_en === 1'b1) begin
            chk("en_needs_tx_ready", 64'(tx_ready), 1);
            chk("byte_expected", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                chk("uart_byte", 64'(uart_data), 64'(mon_exp));
            end
            n_bytes++;
            en_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rec(input logic [31:0] c, input logic [31:0] a, input logic [4:0] r,
                            input logic [1:0] t, input logic [31:0] d, input bit accept);
        string s;
        push     = 1'b1;
        count_in = c;
        info_in  = {d, r, t, a};
        if (accept) begin
            s = line_str(c, a, r, t, d);
            for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        end
        tick();
        push = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while (busy !== 1'b0 && t < 3000) begin
            tick();
            t++;
        end
        chk({tag, "_timeout"}, 64'(t < 3000), 1);
        tick();
        chk({tag, "_drained"}, 64'(exp_q.size()), 0);
    endtask

    task automatic wait_bytes(input string tag, input int target);
        int t = 0;
        while (n_bytes < target && t < 500) begin
            tick();
            t++;
        end
        chk({tag, "_reach"}, 64'(n_bytes), 64'(target));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int base, push_cyc, exp_total, npush;
        string s;

        rst = 1'b1; rdy = 1'b1; push = 1'b0; tx_ready = 1'b1;
        count_in = '0; info_in = '0;
        tick(); tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_uart_en", 64'(uart_en), 0);
        chk("rst_uart_data", 64'(uart_data), 0);
        chk("rst_stall", 64'(stall), 0);
        chk("rst_dropped", 64'(dropped), 0);
        chk("rst_busy", 64'(busy), 0);
        tick();

        // 1: reg line, latency and back-to-back bytes
        base = n_bytes; en_cyc.delete();
        push_cyc = cyc;
        push_rec(32'h1, 32'h0000_1000, 5'd5, 2'd0, 32'hdead_beef, 1'b1);
        chk("t1_busy", 64'(busy), 1);
        wait_idle("t1");
        chk("t1_len", 64'(n_bytes - base), 34);
        chk("t1_latency", 64'(en_cyc[0] - push_cyc), 2);
        chk("t1_contiguous", 64'(en_cyc[33] - en_cyc[0]), 33);

        // 2: store then branch pushed back-to-back
        base = n_bytes; en_cyc.delete();
        push_rec(32'h2, 32'h0000_2000, 5'd0, 2'd1, 32'h0, 1'b1);
        chk("t2_stall_a", 64'(stall), 0);
        push_rec(32'h3, 32'h0000_2004, 5'd0, 2'd2, 32'h1, 1'b1);
        chk("t2_stall_b", 64'(stall), 0);
        wait_idle("t2");
        chk("t2_len", 64'(n_bytes - base), 46);
        chk("t2_gap", 64'((en_cyc[22] - en_cyc[21]) <= 2), 1);

        // 3: tx_ready low for 3 cycles at byte 10
        base = n_bytes;
        push_rec(32'h4, 32'hcafe_0010, 5'h1a, 2'd0, 32'h0123_4567, 1'b1);
        wait_bytes("t3", base + 10);
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_hold_en", 64'(uart_en), 0);
            tick();
        end
        chk("t3_hold_count", 64'(n_bytes - base), 10);
        tx_ready = 1'b1;
        wait_idle("t3");
        chk("t3_len", 64'(n_bytes - base), 34);

        // 4: fill the FIFO behind a stalled line, then overflow once
        base = n_bytes;
        tx_ready = 1'b0;
        push_rec(32'h10, 32'h0000_4000, 5'd1, 2'd3, 32'h0, 1'b1);
        tick(); tick(); tick();
        push_rec(32'h11, 32'h0000_4004, 5'd2, 2'd1, 32'h0, 1'b1);
        push_rec(32'h12, 32'h0000_4008, 5'd3, 2'd2, 32'h0, 1'b1);
        push_rec(32'h13, 32'h0000_400c, 5'd4, 2'd0, 32'hffff_0000, 1'b1);
        chk("t4_stall_3", 64'(stall), 0);
        push_rec(32'h14, 32'h0000_4010, 5'd5, 2'd3, 32'h0, 1'b1);
        chk("t4_stall_4", 64'(stall), 1);
        chk("t4_dropped_pre", 64'(dropped), 0);
        push_rec(32'h15, 32'h0000_4014, 5'd6, 2'd0, 32'h5555_5555, 1'b0);
        chk("t4_dropped", 64'(dropped), 1);
        chk("t4_stall_5", 64'(stall), 1);
        tx_ready = 1'b1;
        wait_idle("t4");
        chk("t4_len", 64'(n_bytes - base), 22 + 22 + 24 + 34 + 22);

        // 5: reset at byte 7 with two records queued
        base = n_bytes;
        push_rec(32'h20, 32'h0000_5000, 5'd7, 2'd0, 32'h1111_1111, 1'b1);
        push_rec(32'h21, 32'h0000_5004, 5'd8, 2'd0, 32'h2222_2222, 1'b1);
        push_rec(32'h22, 32'h0000_5008, 5'd9, 2'd0, 32'h3333_3333, 1'b1);
        wait_bytes("t5", base + 7);
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_uart_en", 64'(uart_en), 0);
        chk("t5_busy", 64'(busy), 0);
        chk("t5_dropped", 64'(dropped), 0);
        chk("t5_stall", 64'(stall), 0);
        chk("t5_partial", 64'(n_bytes - base), 7);
        tick();
        base = n_bytes;
        push_rec(32'h23, 32'h0000_500c, 5'd0, 2'd1, 32'h0, 1'b1);
        wait_idle("t5");
        chk("t5_fresh_len", 64'(n_bytes - base), 22);

        // 6: rdy low for 4 cycles mid-line; a push during the freeze is ignored
        base = n_bytes;
        push_rec(32'h30, 32'h0000_6000, 5'h1f, 2'd0, 32'h89ab_cdef, 1'b1);
        wait_bytes("t6", base + 12);
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push = (i == 1);
            count_in = 32'h99;
            @(negedge clk);
            chk("t6_freeze_en", 64'(uart_en), 0);
            chk("t6_freeze_busy", 64'(busy), 1);
            tick();
        end
        push = 1'b0;
        chk("t6_freeze_count", 64'(n_bytes - base), 12);
        rdy = 1'b1;
        wait_idle("t6");
        chk("t6_len", 64'(n_bytes - base), 34);
        chk("t6_dropped", 64'(dropped), 0);

        // Randomized records under random back-pressure
        base = n_bytes; exp_total = 0; npush = 0;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] c, a, d;
            logic [4:0]  r;
            logic [1:0]  t;
            tx_ready = ($urandom_range(0, 3) != 0);
            if (npush < 25 && $urandom_range(0, 2) == 0 && stall === 1'b0) begin
                c = $urandom; a = $urandom; d = $urandom;
                r = 5'($urandom); t = 2'($urandom);
                s = line_str(c, a, r, t, d);
                for (int j = 0; j < s.len(); j++) exp_q.push_back(s[j]);
                exp_total += s.len();
                push = 1'b1; count_in = c; info_in = {d, r, t, a};
                npush++;
            end else begin
                push = 1'b0;
            end
            tick();
        end
        push = 1'b0;
        tx_ready = 1'b1;
        wait_idle("rand");
        chk("rand_len", 64'(n_bytes - base), 64'(exp_total));
        chk("rand_dropped", 64'(dropped), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
